// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and default constants for the PL SPI master, slave and their benches.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, NEXT, HOLD} spi_mst_state_t;

    localparam int SPI_CS_W    = 2;
    localparam int SPI_CLK_DIV = 4;
    localparam int SPI_DATA_W  = 8;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator; counts 0..DIV-1 while enabled and flags the terminal count.
module spi_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk100,
    input  logic rstn,
    input  logic i_en,
    output logic o_tick
);

    logic [7:0] r_cnt;

    assign o_tick = i_en && (r_cnt == 8'(DIV - 1));

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) r_cnt <= '0;
        else       r_cnt <= (!i_en || o_tick) ? '0 : r_cnt + 8'd1;
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master serialising a valid/ready word stream onto one of NUM_CS chip selects.
// Define SPI_MASTER_LOOPBACK_EN to add loopback_i, which samples mosi_o in place of miso_i.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV,
    parameter int DATA_W  = SPI_DATA_W,
    parameter int NUM_CS  = 3
) (
    input  logic                clk100,
    input  logic                rstn,
    input  logic [DATA_W-1:0]   tx_data_i,
    input  logic                tx_valid_i,
    input  logic                tx_last_i,
    output logic                tx_ready_o,
    input  logic [SPI_CS_W-1:0] cs_sel_i,
    output logic [DATA_W-1:0]   rx_data_o,
    output logic                rx_valid_o,
    output logic                busy_o,
    output logic                sclk_o,
    output logic [NUM_CS-1:0]   csn_o,
    output logic                mosi_o,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                loopback_i,
`endif
    input  logic                miso_i
);

    localparam int EW = $clog2(2 * DATA_W);

    spi_mst_state_t    r_state;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic [EW-1:0]     r_edge;
    logic [NUM_CS-1:0] r_csn;
    logic              r_last;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_rx_valid;
    logic              r_busy;
    logic              w_tick;
    logic              w_sample;
    logic              w_div_en;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_sample = loopback_i ? r_mosi : miso_i;
`else
    assign w_sample = miso_i;
`endif

    // The divider is held at zero while waiting for a word so SETUP always lasts a full half-period.
    assign w_div_en   = (r_state != IDLE) && (r_state != NEXT);
    assign tx_ready_o = rstn && ((r_state == IDLE) || (r_state == NEXT));
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign busy_o     = r_busy;
    assign sclk_o     = r_sclk;
    assign csn_o      = r_csn;
    assign mosi_o     = r_mosi;

    spi_clk_div #(.DIV(CLK_DIV)) u_div (
        .clk100 (clk100),
        .rstn   (rstn),
        .i_en   (w_div_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_edge     <= '0;
            r_csn      <= '1;
            r_last     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                IDLE: if (tx_valid_i) begin
                    r_tx    <= tx_data_i;
                    r_mosi  <= tx_data_i[DATA_W-1];
                    r_last  <= tx_last_i;
                    // An out-of-range index shifts the one out of the vector, leaving all selects high.
                    r_csn   <= ~(NUM_CS'(1) << cs_sel_i);
                    r_busy  <= 1'b1;
                    r_state <= SETUP;
                end
                SETUP: if (w_tick) begin
                    r_edge  <= '0;
                    r_state <= XFER;
                end
                XFER: if (w_tick) begin
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + 1'b1;
                    if (!r_sclk) begin
                        r_rx <= {r_rx[DATA_W-2:0], w_sample};
                    end else if (r_edge == EW'(2 * DATA_W - 1)) begin
                        r_rx_data  <= r_rx;
                        r_rx_valid <= 1'b1;
                        r_state    <= r_last ? HOLD : NEXT;
                    end else begin
                        r_tx   <= r_tx << 1;
                        r_mosi <= r_tx[DATA_W-2];
                    end
                end
                NEXT: if (tx_valid_i) begin
                    r_tx    <= tx_data_i;
                    r_mosi  <= tx_data_i[DATA_W-1];
                    r_last  <= tx_last_i;
                    r_state <= SETUP;
                end
                HOLD: if (w_tick) begin
                    r_csn   <= '1;
                    r_busy  <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed scoreboard bench for spi_master with a mode-0 slave model on MISO.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int D = 4;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         lat;
    } exp_t;

    logic       clk100 = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data_i = '0;
    logic       tx_valid_i = 1'b0;
    logic       tx_last_i = 1'b0;
    logic       tx_ready_o;
    logic [1:0] cs_sel_i = '0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       busy_o;
    logic       sclk_o;
    logic [2:0] csn_o;
    logic       mosi_o;
    logic       miso_i;
    logic       loopback_i = 1'b0;
    logic       miso_zero = 1'b0;

    logic [7:0] s_tx = '0;
    logic [7:0] mcap = '0;
    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         edges = 0;
    int         rises = 0;
    int         cs0_low = 0;
    int         bad_cs = 0;
    int         ready_bad = 0;
    logic [2:0] exp_csn = 3'b111;

    always #5 clk100 = ~clk100;

    assign miso_i = miso_zero ? 1'b0 : s_tx[7];

    spi_master #(.CLK_DIV(D), .DATA_W(8), .NUM_CS(3)) dut (
        .clk100     (clk100),
        .rstn       (rstn),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_last_i  (tx_last_i),
        .tx_ready_o (tx_ready_o),
        .cs_sel_i   (cs_sel_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o),
        .sclk_o     (sclk_o),
        .csn_o      (csn_o),
        .mosi_o     (mosi_o),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback_i (loopback_i),
`endif
        .miso_i     (miso_i)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk100) cyc <= cyc + 1;
    always @(sclk_o) edges++;
    always @(posedge sclk_o) begin
        rises++;
        mcap <= {mcap[6:0], mosi_o};
    end
    always @(negedge sclk_o) s_tx = s_tx << 1;

    always @(negedge clk100) begin
        if (!csn_o[0]) cs0_low++;
        if (busy_o && csn_o !== exp_csn) bad_cs++;
        if (tx_ready_o && sclk_o) ready_bad++;
    end

    // Scoreboard monitor: every rx_valid_o pulse must match the oldest outstanding word.
    always @(negedge clk100) begin
        if (rx_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("rx_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", int'(rx_data_o), int'(e.rx));
                chk("mosi_word", int'(mcap), int'(e.tx));
                if (e.lat >= 0) chk("rx_latency", cyc - acc_cyc + 1, e.lat);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic last, input logic [1:0] sel,
                        input logic [7:0] srsp, input int lat, input bit push);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk100);
            if (tx_ready_o) begin
                s_tx       = srsp;
                tx_data_i  = d;
                tx_last_i  = last;
                cs_sel_i   = sel;
                tx_valid_i = 1'b1;
                if (push) exp_q.push_back('{rx: srsp, tx: d, lat: lat});
                @(posedge clk100);
                #1;
                acc_cyc    = cyc;
                tx_valid_i = 1'b0;
                chk("ready_after_accept", int'(tx_ready_o), 0);
                return;
            end
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk100);
            if (!busy_o) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic chk_reset(input string name);
        chk(name, int'({sclk_o, csn_o, mosi_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o}),
            int'({1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk100);
        chk_reset("reset_values");
        rstn = 1'b1;
        repeat (2) @(negedge clk100);

        // single byte on select 0
        exp_csn = 3'b110; bad_cs = 0; cs0_low = 0; rises = 0;
        send(8'hA5, 1'b1, 2'd0, 8'h3C, 1 + 17 * D, 1'b1);
        wait_idle();
        chk("cs0_low_cycles", cs0_low, 18 * D);
        chk("single_rises", rises, 8);
        chk("single_cs", bad_cs, 0);

        // two-word burst on select 2
        exp_csn = 3'b011; bad_cs = 0; ready_bad = 0;
        send(8'h01, 1'b0, 2'd2, 8'h96, -1, 1'b1);
        send(8'h80, 1'b1, 2'd2, 8'h69, -1, 1'b1);
        wait_idle();
        chk("burst_cs", bad_cs, 0);
        chk("burst_ready", ready_bad, 0);

        // stall in NEXT for 100 cycles
        exp_csn = 3'b101; bad_cs = 0;
        send(8'hC3, 1'b0, 2'd1, 8'h0F, -1, 1'b1);
        begin
            int ok = 0;
            for (int i = 0; i < 5000 && ok == 0; i++) begin
                @(negedge clk100);
                if (tx_ready_o) ok = 1;
            end
            chk("next_reached", ok, 1);
        end
        edges = 0;
        begin
            int stall_bad = 0;
            repeat (100) begin
                @(negedge clk100);
                if (csn_o !== 3'b101 || sclk_o !== 1'b0) stall_bad++;
            end
            chk("stall_lines", stall_bad, 0);
        end
        chk("stall_edges", edges, 0);
        send(8'h3C, 1'b1, 2'd1, 8'hF0, -1, 1'b1);
        wait_idle();
        chk("stall_cs", bad_cs, 0);

        // reset after 5 SCLK edges
        exp_csn = 3'b110;
        send(8'hF0, 1'b1, 2'd0, 8'hAA, -1, 1'b0);
        edges = 0;
        for (int i = 0; i < 5000 && edges < 5; i++) @(negedge clk100);
        chk("abort_edges", edges, 5);
        rstn = 1'b0;
        #1;
        chk_reset("abort_reset");
        repeat (3) @(negedge clk100);
        rstn = 1'b1;
        exp_csn = 3'b101; bad_cs = 0;
        send(8'h55, 1'b1, 2'd1, 8'hC3, 1 + 17 * D, 1'b1);
        wait_idle();
        chk("post_reset_cs", bad_cs, 0);

        // out-of-range select
        exp_csn = 3'b111; bad_cs = 0; edges = 0;
        send(8'hFF, 1'b1, 2'd3, 8'h81, -1, 1'b1);
        wait_idle();
        chk("invalid_sel_edges", edges, 16);
        chk("invalid_sel_cs", bad_cs, 0);

`ifdef SPI_MASTER_LOOPBACK_EN
        exp_csn = 3'b110;
        loopback_i = 1'b1; miso_zero = 1'b1;
        send(8'h5A, 1'b1, 2'd0, 8'h5A, -1, 1'b1);
        wait_idle();
        loopback_i = 1'b0; miso_zero = 1'b0;
`endif

        repeat (4) @(negedge clk100);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
